// File: rtl/conv1d_stream.sv
// Streaming multi-channel 1-D convolution with a K-deep sliding sample window.
// Computes one output channel per cycle, then presents the packed result vector
// through a valid/ready handshake. Weights are writable at runtime while idle.
// Optional build macro: CONV1D_SAT_EN clamps each output lane to the signed
// DATA_WIDTH range instead of wrapping.
module conv1d_stream #(
    parameter int unsigned IN_CH      = 2,
    parameter int unsigned OUT_CH     = 2,
    parameter int unsigned K          = 3,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SHIFT      = 4,
    localparam int unsigned WN        = OUT_CH * K * IN_CH,
    localparam int unsigned AW        = (WN > 1) ? $clog2(WN) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_CH*DATA_WIDTH-1:0]  din,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_CH*DATA_WIDTH-1:0] dout,
    input  logic                         w_we,
    input  logic [AW-1:0]                w_addr,
    input  logic [DATA_WIDTH-1:0]        w_data,
    output logic                         busy
);

    localparam int unsigned ACC_W = 2 * DATA_WIDTH + $clog2(IN_CH * K);
    localparam int unsigned CW    = $clog2(K + 1);
    localparam int unsigned OCW   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    typedef enum logic [1:0] {StIdle, StCompute, StOut} state_e;

    state_e                       state_q, state_d;
    logic [OCW-1:0]               oc_q, oc_d;
    logic [CW-1:0]                count_q, count_d;
    logic signed [DATA_WIDTH-1:0] hist_q [K][IN_CH];
    logic signed [DATA_WIDTH-1:0] w_q [WN];
    logic [OUT_CH*DATA_WIDTH-1:0] dout_q;

    logic                         accept;
    logic                         w_write;
    logic [AW-1:0]                widx;
    logic signed [ACC_W-1:0]      acc;
    logic signed [DATA_WIDTH-1:0] lane;

    assign accept  = in_valid && (state_q == StIdle);
    // Out-of-range addresses and writes while busy are silently dropped.
    assign w_write = w_we && (state_q == StIdle) && (32'(w_addr) < WN);

    // Sample count including the sample being accepted, saturating at K.
    always_comb begin
        count_d = count_q;
        if (accept && (count_q < CW'(K))) begin
            count_d = count_q + 1'b1;
        end
    end

    // Next-state logic: warm-up stays idle until the window is full.
    always_comb begin
        state_d = state_q;
        oc_d    = oc_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (count_d == CW'(K))) begin
                    state_d = StCompute;
                    oc_d    = '0;
                end
            end
            StCompute: begin
                if (oc_q == OCW'(OUT_CH - 1)) begin
                    state_d = StOut;
                end else begin
                    oc_d = oc_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Full-precision dot product of the window with the weights of channel oc_q.
    always_comb begin
        acc  = '0;
        widx = '0;
        for (int k = 0; k < int'(K); k++) begin
            for (int ic = 0; ic < int'(IN_CH); ic++) begin
                widx = AW'(int'(oc_q) * int'(K * IN_CH) + k * int'(IN_CH) + ic);
                acc  = acc + ACC_W'(w_q[widx]) * ACC_W'(hist_q[k][ic]);
            end
        end
    end

`ifdef CONV1D_SAT_EN
    localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_W-1:0] SatMin = ACC_W'(-(2 ** (DATA_WIDTH - 1)));

    logic signed [ACC_W-1:0] res;

    // Rescale with floor shift, then clamp into the output range.
    always_comb begin
        res = acc >>> SHIFT;
        if (res > SatMax) begin
            lane = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (res < SatMin) begin
            lane = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            lane = DATA_WIDTH'(res);
        end
    end
`else
    // Rescale with floor shift and keep the low bits (two's-complement wrap).
    always_comb begin
        lane = DATA_WIDTH'(acc >>> SHIFT);
    end
`endif

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            oc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            oc_q    <= oc_d;
            count_q <= count_d;
        end
    end

    // Sample history: index 0 holds the newest sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(K); k++) begin
                for (int ic = 0; ic < int'(IN_CH); ic++) begin
                    hist_q[k][ic] <= '0;
                end
            end
        end else if (accept) begin
            for (int ic = 0; ic < int'(IN_CH); ic++) begin
                hist_q[0][ic] <= din[ic*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int k = 1; k < int'(K); k++) begin
                for (int ic = 0; ic < int'(IN_CH); ic++) begin
                    hist_q[k][ic] <= hist_q[k-1][ic];
                end
            end
        end
    end

    // Weight file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(WN); i++) begin
                w_q[i] <= '0;
            end
        end else if (w_write) begin
            w_q[w_addr] <= w_data;
        end
    end

    // Result register: one lane filled per compute cycle, held through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (state_q == StCompute) begin
            dout_q[oc_q*DATA_WIDTH +: DATA_WIDTH] <= lane;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = !in_ready;
    assign out_valid = (state_q == StOut);
    assign dout      = dout_q;

endmodule

// File: tb/tb_conv1d_stream.sv
// Self-checking bench for conv1d_stream. Two instances (SHIFT=0 and SHIFT=2)
// share all stimulus; a behavioural model pushes full-precision accumulator
// values to a scoreboard, and each instance's lanes are checked on output.
// Honours CONV1D_SAT_EN for the expected lane values.
module tb_conv1d_stream;

    localparam int IN_CH  = 2;
    localparam int OUT_CH = 2;
    localparam int K      = 3;
    localparam int DW     = 16;
    localparam int WN     = OUT_CH * K * IN_CH;
    localparam int AW     = $clog2(WN);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 out_ready;
    logic                 w_we;
    logic [IN_CH*DW-1:0]  din;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_data;

    logic                 in_ready0, out_valid0, busy0;
    logic                 in_ready2, out_valid2, busy2;
    logic [OUT_CH*DW-1:0] dout0, dout2;

    int     checks = 0;
    int     errors = 0;
    longint wm [WN];
    longint xm [K][IN_CH];
    int     cnt;
    longint exp_q [$];

    always #5 clk = ~clk;

    conv1d_stream #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .K(K), .DATA_WIDTH(DW), .SHIFT(0)
    ) u_dut_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .din(din),
        .out_valid(out_valid0), .out_ready(out_ready), .dout(dout0), .w_we(w_we),
        .w_addr(w_addr), .w_data(w_data), .busy(busy0)
    );

    conv1d_stream #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .K(K), .DATA_WIDTH(DW), .SHIFT(2)
    ) u_dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .din(din),
        .out_valid(out_valid2), .out_ready(out_ready), .dout(dout2), .w_we(w_we),
        .w_addr(w_addr), .w_data(w_data), .busy(busy2)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint expect_lane(input longint acc, input int sh);
        longint r;
        logic [DW-1:0] lo;
        r = acc >>> sh;
`ifdef CONV1D_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        lo = r[DW-1:0];
`else
        lo = r[DW-1:0];
`endif
        return longint'($signed(lo));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WN; i++) wm[i] = 0;
        for (int k = 0; k < K; k++)
            for (int ic = 0; ic < IN_CH; ic++) xm[k][ic] = 0;
        cnt = 0;
        exp_q.delete();
    endtask

    // Weight write in idle; 'lands' says whether the model should take it.
    task automatic wr(input int addr, input longint data, input bit lands);
        w_we   = 1'b1;
        w_addr = addr[AW-1:0];
        w_data = data[DW-1:0];
        @(posedge clk);
        if (lands && addr < WN) wm[addr] = data;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // Drive one sample (optionally with a same-cycle weight write); returns at
    // the negedge right after the accepting edge.
    task automatic send(input longint a, input longint b, input bit do_wr = 1'b0,
                        input int addr = 0, input longint data = 0);
        int n = 0;
        longint acc;
        while (!in_ready0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_in_ready", in_ready0, 1);
        din      = {b[DW-1:0], a[DW-1:0]};
        in_valid = 1'b1;
        if (do_wr) begin
            w_we   = 1'b1;
            w_addr = addr[AW-1:0];
            w_data = data[DW-1:0];
        end
        @(posedge clk);
        if (do_wr && addr < WN) wm[addr] = data;
        for (int k = K - 1; k > 0; k--)
            for (int ic = 0; ic < IN_CH; ic++) xm[k][ic] = xm[k-1][ic];
        xm[0][0] = a;
        xm[0][1] = b;
        if (cnt < K) cnt++;
        if (cnt == K) begin
            for (int oc = 0; oc < OUT_CH; oc++) begin
                acc = 0;
                for (int k = 0; k < K; k++)
                    for (int ic = 0; ic < IN_CH; ic++)
                        acc += wm[oc*K*IN_CH + k*IN_CH + ic] * xm[k][ic];
                exp_q.push_back(acc);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        w_we     = 1'b0;
    endtask

    task automatic quiet();
        repeat (4) @(negedge clk);
        check("warmup_no_valid", out_valid0, 0);
        check("warmup_in_ready", in_ready0, 1);
    endtask

    // Wait for a result (start = cycles already elapsed since accept), hold
    // back-pressure for 'hold' cycles, compare against the scoreboard, transfer.
    task automatic collect(input int start, input int hold);
        int n = start;
        logic [OUT_CH*DW-1:0] snap;
        longint acc;
        while (!out_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, OUT_CH + 1);
        check("valid_s2", out_valid2, 1);
        check("out_in_ready", in_ready0, 0);
        check("out_busy", busy0, 1);
        snap = dout0;
        repeat (hold) begin
            @(negedge clk);
            check("bp_valid", out_valid0, 1);
            check("bp_stable", dout0, snap);
            check("bp_in_ready", in_ready0, 0);
        end
        for (int oc = 0; oc < OUT_CH; oc++) begin
            if (exp_q.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                acc = exp_q.pop_front();
                check("dout_s0", $signed(dout0[oc*DW +: DW]), expect_lane(acc, 0));
                check("dout_s2", $signed(dout2[oc*DW +: DW]), expect_lane(acc, 2));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid0, 0);
        check("post_in_ready", in_ready0, 1);
        check("post_busy", busy0, 0);
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        w_we      = 1'b0;
        din       = '0;
        w_addr    = '0;
        w_data    = '0;
        rst       = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_dout", dout0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: oc0 all ones, oc1 uses newest sample only.
        for (int i = 0; i < K * IN_CH; i++) wr(i, 1, 1'b1);
        wr(6, 3, 1'b1);
        wr(7, 5, 1'b1);
        send(1, 2);
        quiet();
        send(3, 4);
        quiet();
        send(5, 6);
        collect(1, 0);
        send(7, 8);
        collect(1, 0);

        // Back-pressure.
        send(9, 10);
        collect(1, 5);

        // Overflow: only w[0][0][0] nonzero; out-of-range address is ignored.
        for (int i = 0; i < WN; i++) wr(i, 0, 1'b1);
        wr(0, 32767, 1'b1);
        wr(13, 100, 1'b0);
        send(32767, 0);
        collect(1, 0);

        // Floor shift of negative and positive accumulators.
        wr(0, -5, 1'b1);
        send(1, 0);
        collect(1, 0);
        wr(0, 5, 1'b1);
        send(1, 0);
        collect(1, 0);

        // Weight write during compute is dropped.
        send(1, 0);
        w_we   = 1'b1;
        w_addr = '0;
        w_data = 16'd9;
        @(negedge clk);
        w_we = 1'b0;
        collect(2, 0);
        wr(0, 9, 1'b1);
        send(1, 0);
        collect(1, 0);
        // Write and accept in the same cycle: new weight is used.
        send(1, 0, 1'b1, 0, 2);
        collect(1, 0);

        // Reset mid-compute clears state, weights and history.
        send(2, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_in_ready", in_ready0, 1);
        check("midrst_busy", busy0, 0);
        check("midrst_dout", dout0, 0);
        rst = 1'b0;
        model_reset();
        send(4, 5);
        quiet();
        send(6, 7);
        quiet();
        send(8, 9);
        collect(1, 0);
        wr(0, 1, 1'b1);
        wr(5, 1, 1'b1);
        wr(11, -2, 1'b1);
        send(10, 11);
        collect(1, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
